a2d_spi_responder: RTL

- Synthesizable SPI slave that emulates the 8-channel A2D converter on the A2D_SS_n/A2D_SCLK/A2D_MOSI/A2D_MISO interface.
- It is the responder end of the link that the Segway A2D interface master drives.
- Lets a bench or FPGA bring-up board supply load-cell, steering-pot and battery readings from registers instead of the behavioural converter model.
- Runs entirely in the system clk domain and oversamples the SPI pins.

---
 rtl/a2d_pkg.sv | 15 +
 rtl/a2d_spi_responder_if.sv | 12 +
 rtl/spi_pin_sync.sv | 33 +++
 rtl/a2d_spi_responder.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/a2d_pkg.sv
// rtl/a2d_pkg.sv - shared types and frame geometry for the A2D SPI responder
package a2d_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int FRAME_BITS = 16;
    localparam int CHNL_MSB   = 13;
    localparam int CHNL_LSB   = 11;
    localparam int DATA_W     = 12;

endpackage

// File: rtl/a2d_spi_responder_if.sv
// rtl/a2d_spi_responder_if.sv - SPI pin bundle between A2D master and responder
interface a2d_spi_responder_if;

    logic SS_n;
    logic SCLK;
    logic MOSI;
    logic MISO;

    modport master (output SS_n, output SCLK, output MOSI, input MISO);
    modport slave  (input SS_n, input SCLK, input MOSI, output MISO);

endinterface

// File: rtl/spi_pin_sync.sv
// rtl/spi_pin_sync.sv - two-flop synchronizer plus edge-detect flop for one SPI pin
module spi_pin_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
            r_prev <= RESET_VAL;
        end else begin
            r_meta <= i_pin;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_prev;
    assign o_fall  = ~r_sync & r_prev;

endmodule

// File: rtl/a2d_spi_responder.sv
// rtl/a2d_spi_responder.sv - SPI slave emulating the 8-channel A2D converter
// Frame N returns the channel addressed by frame N-1; the value is snapshotted at SS_n fall.
module a2d_spi_responder
    import a2d_pkg::*;
#(
    parameter logic [2:0]        LFT_CHNL     = 3'd0,
    parameter logic [2:0]        RGHT_CHNL    = 3'd4,
    parameter logic [2:0]        STEER_CHNL   = 3'd5,
    parameter logic [2:0]        BATT_CHNL    = 3'd6,
    parameter logic [DATA_W-1:0] UNMAPPED_VAL = 12'h000
) (
    input  logic                clk,
    input  logic                rst,
    a2d_spi_responder_if.slave  spi,
    input  logic [DATA_W-1:0]   ld_cell_lft,
    input  logic [DATA_W-1:0]   ld_cell_rght,
    input  logic [DATA_W-1:0]   steerPot,
    input  logic [DATA_W-1:0]   batt,
    output logic                xfer_done,
    output logic                xfer_abort,
    output logic [2:0]          last_chnl
);

    logic w_ss_level, w_ss_rise, w_ss_fall;
    logic w_sclk_level, w_sclk_rise, w_sclk_fall;
    logic w_mosi, w_mosi_rise, w_mosi_fall;

    spi_pin_sync #(.RESET_VAL(1'b1)) u_ss_sync (
        .clk(clk), .rst(rst), .i_pin(spi.SS_n),
        .o_level(w_ss_level), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
    );

    spi_pin_sync #(.RESET_VAL(1'b1)) u_sclk_sync (
        .clk(clk), .rst(rst), .i_pin(spi.SCLK),
        .o_level(w_sclk_level), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    spi_pin_sync #(.RESET_VAL(1'b0)) u_mosi_sync (
        .clk(clk), .rst(rst), .i_pin(spi.MOSI),
        .o_level(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );

    state_t                  r_state;
    state_t                  w_next;
    logic [FRAME_BITS-1:0]   r_tx;
    logic [FRAME_BITS-1:0]   r_rx;
    logic [4:0]              r_bit_cnt;
    logic [2:0]              r_pending;
    logic [2:0]              r_last_chnl;
    logic                    r_done;
    logic                    r_abort;

    logic                    w_load;
    logic                    w_rx_shift;
    logic                    w_tx_shift;
    logic                    w_done;
    logic                    w_abort;
    logic [DATA_W-1:0]       w_sel_val;
    logic [FRAME_BITS-1:0]   w_rx_word;

    // Edge outputs and levels this block has no use for
    logic w_unused;
    assign w_unused = &{1'b0, w_ss_level, w_sclk_level, w_mosi_rise, w_mosi_fall, r_rx[FRAME_BITS-1]};

    assign w_rx_word = {r_rx[FRAME_BITS-2:0], w_mosi};

    always_comb begin
        w_sel_val = UNMAPPED_VAL;
        if (r_pending == LFT_CHNL)
            w_sel_val = ld_cell_lft;
        else if (r_pending == RGHT_CHNL)
            w_sel_val = ld_cell_rght;
        else if (r_pending == STEER_CHNL)
            w_sel_val = steerPot;
        else if (r_pending == BATT_CHNL)
            w_sel_val = batt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_rx_shift = 1'b0;
        w_tx_shift = 1'b0;
        w_done     = 1'b0;
        w_abort    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_ss_fall) begin
                    w_next = SHIFT;
                    w_load = 1'b1;
                end
            end
            SHIFT: begin
                if (w_sclk_rise) begin
                    w_rx_shift = 1'b1;
                    if (r_bit_cnt == 5'(FRAME_BITS - 1)) begin
                        w_done = 1'b1;
                        // A select release coincident with the last edge still completes
                        w_next = w_ss_rise ? IDLE : DRAIN;
                    end
                end
                if (w_sclk_fall && (r_bit_cnt != 5'd0) && (r_bit_cnt < 5'(FRAME_BITS)))
                    w_tx_shift = 1'b1;
                if (w_ss_rise && !w_done) begin
                    w_abort = 1'b1;
                    w_next  = IDLE;
                end
            end
            DRAIN: begin
                if (w_ss_rise)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx        <= '0;
            r_rx        <= '0;
            r_bit_cnt   <= '0;
            r_pending   <= '0;
            r_last_chnl <= '0;
            r_done      <= 1'b0;
            r_abort     <= 1'b0;
        end else begin
            r_done  <= w_done;
            r_abort <= w_abort;
            if (w_load) begin
                r_tx      <= {{(FRAME_BITS - DATA_W){1'b0}}, w_sel_val};
                r_rx      <= '0;
                r_bit_cnt <= '0;
            end else begin
                if (w_rx_shift) begin
                    r_rx      <= w_rx_word;
                    r_bit_cnt <= r_bit_cnt + 5'd1;
                end
                if (w_tx_shift)
                    r_tx <= {r_tx[FRAME_BITS-2:0], 1'b0};
            end
            if (w_done) begin
                r_pending   <= w_rx_word[CHNL_MSB:CHNL_LSB];
                r_last_chnl <= w_rx_word[CHNL_MSB:CHNL_LSB];
            end
        end
    end

    assign spi.MISO   = (r_state == SHIFT) ? r_tx[FRAME_BITS-1] : 1'b0;
    assign xfer_done  = r_done;
    assign xfer_abort = r_abort;
    assign last_chnl  = r_last_chnl;

endmodule
